qspi_cmd_ctrl: RTL and testbench

- Command sequencer between the QSPI slave byte engines (qspislave_rx / qspislave_tx) and an on-chip 8-bit register bus.
- Parses framed host transactions (opcode, address, data) and issues single-cycle bus writes and reads with address auto-increment.
- Prefetches read data into the tx byte path so it is ready before the host clocks it out.
- Sits in the chip top between the QSPI slave pair and peripheral registers (LEDs, debug probes, PLL/clock select).

---
 rtl/qspi_pkg.sv | 26 ++
 rtl/qspi_bus_timer.sv | 36 +++
 rtl/qspi_cmd_ctrl.sv | 129 ++++++++++++
 tb/tb_qspi_cmd_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared opcodes, sequencer state encoding and status byte for the QSPI command path.
// Pure definitions; no timing or flow control of its own.
// Imported by the sequencer and its bus timer.
package qspi_pkg;

    localparam logic [7:0] OP_NOP            = 8'h00;
    localparam logic [7:0] OP_WRITE          = 8'h01;
    localparam logic [7:0] OP_READ           = 8'h02;
    localparam logic [7:0] STAT_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WACK,
        RREQ,
        RACK,
        RDATA,
        DISCARD
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/qspi_bus_timer.sv
// Loadable down-counter guarding a bus request; expired once the count reaches zero.
// Load on start, one decrement per cycle, expired is combinational from the count.
// No backpressure; clear stops it, start has priority over clear.
module qspi_bus_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         clear,
    input  logic [W-1:0] load,
    output logic         expired
);

    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt;
    logic         run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= load;
            run <= 1'b1;
        end else if (clear) begin
            run <= 1'b0;
        end else if (run && cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/qspi_cmd_ctrl.sv
// Frames host bytes into register bus writes/reads with address auto-increment and read prefetch.
// rx_valid to bus_we 1 cycle; bus_re to tx_data = ack latency + 1; strobes last one cycle.
// No stall path to the host: late bytes or early tx_ready count as errors, bus stalls time out.
module qspi_cmd_ctrl
    import qspi_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          TIMEOUT   = 15,
    parameter logic [7:0]  STAT_BYTE = STAT_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [3:0]        TMO_LOAD = 4'(TIMEOUT - 1);

    state_t state;
    logic   is_read;
    logic   tmo_start;
    logic   tmo_clear;
    logic   tmo_expired;

    // Timer is armed on the same edge that raises the strobe, so WACK/RACK get exactly TIMEOUT cycles.
    assign tmo_start = !cs_n && ((state == WDATA && rx_valid) || state == RREQ);
    assign tmo_clear = cs_n || bus_ack;

    qspi_bus_timer #(.W(4)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (tmo_start),
        .clear   (tmo_clear),
        .load    (TMO_LOAD),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            is_read   <= 1'b0;
            tx_data   <= STAT_BYTE;
            bus_addr  <= '0;
            bus_wdata <= 8'h00;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= 8'h00;
        end else begin
            bus_we <= 1'b0;
            bus_re <= 1'b0;
            if (cs_n) begin
                state   <= IDLE;
                busy    <= 1'b0;
                tx_data <= STAT_BYTE;
            end else begin
                case (state)
                    IDLE: if (rx_valid) begin
                        busy <= 1'b1;
                        case (rx_data)
                            OP_WRITE: begin is_read <= 1'b0; state <= ADDR; end
                            OP_READ:  begin is_read <= 1'b1; state <= ADDR; end
                            OP_NOP:   state <= DISCARD;
                            default: begin
                                err_cnt <= sat_inc(err_cnt);
                                state   <= DISCARD;
                            end
                        endcase
                    end
                    ADDR: if (rx_valid) begin
                        bus_addr <= rx_data[ADDR_W-1:0];
                        state    <= is_read ? RREQ : WDATA;
                    end
                    WDATA: if (rx_valid) begin
                        bus_wdata <= rx_data;
                        bus_we    <= 1'b1;
                        state     <= WACK;
                    end
                    WACK: begin
                        if (rx_valid || (!bus_ack && tmo_expired))
                            err_cnt <= sat_inc(err_cnt);
                        if (bus_ack) begin
                            bus_addr <= bus_addr + ADDR_ONE;
                            state    <= WDATA;
                        end else if (tmo_expired) begin
                            tx_data <= STAT_BYTE;
                            state   <= DISCARD;
                        end
                    end
                    RREQ: begin
                        if (tx_ready)
                            err_cnt <= sat_inc(err_cnt);
                        bus_re <= 1'b1;
                        state  <= RACK;
                    end
                    RACK: begin
                        if (tx_ready || (!bus_ack && tmo_expired))
                            err_cnt <= sat_inc(err_cnt);
                        if (bus_ack) begin
                            tx_data <= bus_rdata;
                            state   <= RDATA;
                        end else if (tmo_expired) begin
                            tx_data <= STAT_BYTE;
                            state   <= DISCARD;
                        end
                    end
                    RDATA: if (tx_ready) begin
                        bus_addr <= bus_addr + ADDR_ONE;
                        state    <= RREQ;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_cmd_ctrl.sv
// Directed bench for qspi_cmd_ctrl: write/read bursts, bad opcode, timeout, abort, saturation, async reset.
module tb_qspi_cmd_ctrl;

    logic       clk;
    logic       reset;
    logic       cs_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;
    logic       bus_ack;
    logic       busy;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // 0: ack same cycle as strobe, 2: ack two cycles later, 3: never
    logic [1:0] ack_mode = 2'd0;
    logic       force_ack = 1'b0;
    logic       d1 = 1'b0;
    logic       d2 = 1'b0;

    int         we_cnt = 0;
    int         re_cnt = 0;
    int         both_hi = 0;
    logic [7:0] we_addr [16];
    logic [7:0] we_dat  [16];

    qspi_cmd_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cs_n      (cs_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .busy      (busy),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus_rdata = bus_addr ^ 8'hFF;
    assign bus_ack   = ((ack_mode == 2'd0) ? (bus_we | bus_re) :
                        (ack_mode == 2'd2) ? d2 : 1'b0) | force_ack;

    always @(posedge clk) begin
        d1 <= bus_we | bus_re;
        d2 <= d1;
        if (bus_we) begin
            we_addr[we_cnt % 16] <= bus_addr;
            we_dat[we_cnt % 16]  <= bus_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (bus_re) re_cnt <= re_cnt + 1;
        if (bus_we && bus_re) both_hi <= both_hi + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_ready();
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks++;
        if ({tx_data, bus_addr, bus_wdata, bus_we, bus_re, busy, err_cnt} !== {8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values got tx=%h addr=%h wd=%h we=%b re=%b busy=%b err=%h want A5 00 00 0 0 0 00",
                     tx_data, bus_addr, bus_wdata, bus_we, bus_re, busy, err_cnt);
        end
        reset = 1'b0;
        idle(2);
        checks++;
        if (busy !== 1'b0 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b tx=%h want 0 A5", busy, tx_data);
        end
    endtask

    task automatic test_write_burst();
        int w0;
        ack_mode = 2'd0;
        w0 = we_cnt;
        cs_n = 1'b0;
        idle(1);
        send_byte(8'h01); idle(1);
        send_byte(8'h10); idle(1);
        send_byte(8'hAA);
        checks++;
        if (bus_we !== 1'b1 || bus_addr !== 8'h10 || bus_wdata !== 8'hAA) begin
            errors++;
            $display("FAIL write_latency got we=%b addr=%h wd=%h want 1 10 AA", bus_we, bus_addr, bus_wdata);
        end
        idle(1);
        send_byte(8'hBB);
        idle(3);
        checks++;
        if (we_cnt - w0 !== 2) begin
            errors++;
            $display("FAIL write_count got %0d want 2", we_cnt - w0);
        end
        checks++;
        if (we_addr[w0 % 16] !== 8'h10 || we_dat[w0 % 16] !== 8'hAA) begin
            errors++;
            $display("FAIL write_first got %h/%h want 10/AA", we_addr[w0 % 16], we_dat[w0 % 16]);
        end
        checks++;
        if (we_addr[(w0 + 1) % 16] !== 8'h11 || we_dat[(w0 + 1) % 16] !== 8'hBB) begin
            errors++;
            $display("FAIL write_second got %h/%h want 11/BB", we_addr[(w0 + 1) % 16], we_dat[(w0 + 1) % 16]);
        end
        checks++;
        if (err_cnt !== 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL write_status got err=%h busy=%b want 00 1", err_cnt, busy);
        end
        end_frame();
        checks++;
        if (busy !== 1'b0 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL write_end got busy=%b tx=%h want 0 A5", busy, tx_data);
        end
    endtask

    task automatic test_read_burst();
        int r0;
        logic [7:0] exp_tx [3];
        exp_tx[0] = 8'h01;
        exp_tx[1] = 8'h00;
        exp_tx[2] = 8'hFF;
        ack_mode = 2'd2;
        r0 = re_cnt;
        cs_n = 1'b0;
        idle(1);
        send_byte(8'h02); idle(1);
        send_byte(8'hFE);
        for (int i = 0; i < 3; i++) begin
            idle(6);
            checks++;
            if (tx_data !== exp_tx[i]) begin
                errors++;
                $display("FAIL read_data_%0d got %h want %h", i, tx_data, exp_tx[i]);
            end
            pulse_ready();
        end
        idle(6);
        checks++;
        if (re_cnt - r0 !== 4 || bus_addr !== 8'h01) begin
            errors++;
            $display("FAIL read_wrap got re=%0d addr=%h want 4 01", re_cnt - r0, bus_addr);
        end
        checks++;
        if (err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL read_err got %h want 00", err_cnt);
        end
        end_frame();
        checks++;
        if (tx_data !== 8'hA5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_end got tx=%h busy=%b want A5 0", tx_data, busy);
        end
    endtask

    task automatic test_bad_opcode();
        int w0, r0;
        ack_mode = 2'd0;
        w0 = we_cnt;
        r0 = re_cnt;
        cs_n = 1'b0;
        idle(1);
        send_byte(8'h7E); idle(1);
        send_byte(8'h12); idle(1);
        send_byte(8'h34); idle(2);
        checks++;
        if (err_cnt !== 8'h01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL badop_err got err=%h busy=%b want 01 1", err_cnt, busy);
        end
        checks++;
        if (we_cnt != w0 || re_cnt != r0) begin
            errors++;
            $display("FAIL badop_strobes got we=%0d re=%0d want 0 0", we_cnt - w0, re_cnt - r0);
        end
        end_frame();
        checks++;
        if (busy !== 1'b0 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL badop_end got busy=%b tx=%h want 0 A5", busy, tx_data);
        end
    endtask

    task automatic test_timeout();
        int w0;
        ack_mode = 2'd3;
        w0 = we_cnt;
        cs_n = 1'b0;
        idle(1);
        send_byte(8'h01); idle(1);
        send_byte(8'h20); idle(1);
        send_byte(8'h55);
        checks++;
        if (bus_we !== 1'b1 || bus_wdata !== 8'h55) begin
            errors++;
            $display("FAIL tmo_strobe got we=%b wd=%h want 1 55", bus_we, bus_wdata);
        end
        idle(14);
        checks++;
        if (err_cnt !== 8'h01) begin
            errors++;
            $display("FAIL tmo_early got err=%h want 01", err_cnt);
        end
        idle(1);
        checks++;
        if (err_cnt !== 8'h02 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_fire got err=%h busy=%b want 02 1", err_cnt, busy);
        end
        send_byte(8'h66); idle(1);
        send_byte(8'h77); idle(2);
        checks++;
        if (err_cnt !== 8'h02 || we_cnt - w0 !== 1 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL tmo_discard got err=%h we=%0d tx=%h want 02 1 A5", err_cnt, we_cnt - w0, tx_data);
        end
        end_frame();
    endtask

    task automatic test_abort();
        int r0;
        ack_mode = 2'd3;
        r0 = re_cnt;
        cs_n = 1'b0;
        idle(1);
        send_byte(8'h02); idle(1);
        send_byte(8'h40);
        idle(2);
        checks++;
        if (re_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL abort_re got %0d want 1", re_cnt - r0);
        end
        cs_n = 1'b1;
        idle(1);
        checks++;
        if (busy !== 1'b0 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL abort_idle got busy=%b tx=%h want 0 A5", busy, tx_data);
        end
        force_ack = 1'b1;
        idle(1);
        force_ack = 1'b0;
        idle(3);
        checks++;
        if (re_cnt - r0 !== 1 || busy !== 1'b0 || tx_data !== 8'hA5 || err_cnt !== 8'h02) begin
            errors++;
            $display("FAIL abort_late_ack got re=%0d busy=%b tx=%h err=%h want 1 0 A5 02",
                     re_cnt - r0, busy, tx_data, err_cnt);
        end
    endtask

    task automatic test_wack_drop();
        int w0;
        ack_mode = 2'd3;
        w0 = we_cnt;
        cs_n = 1'b0;
        idle(1);
        send_byte(8'h01); idle(1);
        send_byte(8'h30); idle(1);
        send_byte(8'h11); idle(1);
        send_byte(8'h22); idle(1);
        checks++;
        if (err_cnt !== 8'h03 || we_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL wack_drop got err=%h we=%0d want 03 1", err_cnt, we_cnt - w0);
        end
        end_frame();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            cs_n = 1'b0;
            send_byte(8'hC3);
            cs_n = 1'b1;
            idle(1);
        end
        checks++;
        if (err_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL err_saturate got %h want FF", err_cnt);
        end
    endtask

    task automatic test_async_reset();
        ack_mode = 2'd0;
        cs_n = 1'b0;
        idle(1);
        send_byte(8'h01); idle(1);
        send_byte(8'h50); idle(1);
        checks++;
        if (bus_addr !== 8'h50 || busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got addr=%h busy=%b want 50 1", bus_addr, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_data, bus_addr, bus_wdata, bus_we, bus_re, busy, err_cnt} !== {8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL areset_values got tx=%h addr=%h wd=%h we=%b re=%b busy=%b err=%h want A5 00 00 0 0 0 00",
                     tx_data, bus_addr, bus_wdata, bus_we, bus_re, busy, err_cnt);
        end
        cs_n = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
    endtask

    initial begin
        reset    = 1'b1;
        cs_n     = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_bad_opcode();
        test_timeout();
        test_abort();
        test_wack_drop();
        test_saturate();
        test_async_reset();
        checks++;
        if (both_hi != 0) begin
            errors++;
            $display("FAIL strobe_overlap got %0d want 0", both_hi);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
